r88_regfile_gen: RTL and testbench
==================================

# r88_regfile_gen

Parametrised register file for the Rocket88 core, replacing the fixed A/B/C + DD/EE/PC/SP register block. It holds a configurable number of general-purpose registers and 16-bit pointer pairs, a status register, a program counter with auto-increment and a stack pointer with push/pop adjust. It also provides registered right, left and address operand outputs for the ALU and bus unit. It sits between the internal data bus logic, the ALU operand muxes and the address generator.

## Interface
- DATA_W, 8, register/byte width; ADDR_W is fixed at 2*DATA_W
- NUM_GPR, 3, general-purpose registers (index 0 is the accumulator)
- NUM_PAIR, 4, pointer pairs; the last two are PC then SP, so NUM_PAIR ≥ 2
- RESET_PC, 16'h0000, PC reset value
- RESET_SP, 16'hFFF9, SP reset value
- Derived: NREG = NUM_GPR + 2*NUM_PAIR + 1; SEL_W = clog2(NREG)

Ports:
- sysClock  in  1  system clock, all state on rising edge
- sysResetN  in  1  asynchronous active-low reset
- wrEn  in  1  write strobe
- wrSel  in  SEL_W  write register index
- wrWide  in  1  pair write: wrData goes to the low byte and wrDataHi to the high byte
- wrData, wrDataHi  in  DATA_W each  write data
- rdSel  in  SEL_W  bus read index
- rdData  out  DATA_W  registered bus read data
- rightSel  in  clog2(NUM_GPR+1)  0 = zero, k = GPR k-1
- rightData  out  DATA_W  registered ALU right operand
- leftSel  in  clog2(NUM_PAIR)  pair select; selects GPR (0 = zero) when leftWide=0
- leftWide  in  1  16-bit left operand
- leftData  out  ADDR_W  registered ALU left operand, zero-extended when narrow
- addrSel  in  clog2(NUM_PAIR+1)  0 = {GPR1,GPR2}, k = pair k-1
- addrOut  out  ADDR_W  registered address
- incPC  in  1  PC += 1
- spPush, spPop  in  1 each  SP -= 1 / SP += 1
- flagsLoad  in  1  load status from flagsIn
- flagsIn  in  DATA_W  {S,Z,C,I,D,B,0,0}
- flagsOut  out  DATA_W  live status register
- regErr  out  1  one-cycle pulse on an illegal access

## Operation
- Index map:
  - 0..NUM_GPR-1 are GPRs.
  - Pair p has its low byte at NUM_GPR+2p and its high byte at NUM_GPR+2p+1.
  - STATUS is at NREG-1.
  - Indices ≥ NREG read 0 and ignore writes.
- Per-register update priority on the same edge, highest first:
  - wrEn (byte or wide)
  - flagsLoad (STATUS only)
  - incPC (PC) or spPush/spPop (SP)
- Unaffected bytes of a pair hold their value on a byte write.
- wrWide with wrSel not at a pair low byte: no write occurs and regErr pulses.
- spPush and spPop asserted together: SP unchanged, regErr pulses.
- Any write to an index ≥ NREG also pulses regErr.
- Arithmetic:
  - PC FFFF+1 wraps to 0000.
  - SP 0000-1 wraps to FFFF; FFFF+1 wraps to 0000.
  - All arithmetic is modulo 2^ADDR_W with no carry out.
- Reset values:
  - All GPRs and non-PC/SP pairs are 0; PC = RESET_PC; SP = RESET_SP; STATUS = 0.
  - rdData, rightData, leftData, addrOut and regErr are 0.
  - Reset mid-operation overrides every strobe immediately.

## Timing
- All outputs except flagsOut are registered with 1-cycle latency. Each output at edge n+1 reflects the selects applied before edge n+1, sampled from register state as of edge n. This is pre-update state unless forwarding is enabled (see Configuration).
- flagsOut is combinational from the STATUS register; it has no extra delay.
- No handshakes. Strobes are single-cycle and may be held; holding incPC for N cycles adds N.

## Configuration
- R88_REGFILE_FWD_EN: when defined, rdData, rightData, leftData and addrOut reflect the post-update value of any register written, incremented or adjusted on the same edge. This gives write-then-read in back-to-back cycles with no stale data.
- Without the macro, those outputs show the pre-update value; the sequencer must insert one idle cycle.

## Structure
- Package r88_pkg holds:
  - reset constants, status bit positions (S=7, Z=6, C=5, I=4, D=3, B=2)
  - index helper functions (pair low index, STATUS index)
  - the pair-role constants PC_PAIR = NUM_PAIR-2 and SP_PAIR = NUM_PAIR-1
- Sub-module r88_ptr_reg: one ADDR_W pair register with byte/wide write, +1/-1 adjust and priority logic. It is instantiated per pair, with unused adjust inputs tied low.

## Test plan
- Reset with default params → PC=0000, SP=FFF9, A=0, all outputs 0, regErr=0; assert sysResetN low mid-write → state returns to reset values without waiting for a clock edge.
- Write PC low=FF, high=FF; incPC one cycle; addrSel=PC → addrOut=0000.
- spPush at SP=0000 → SP=FFFF; then spPush+spPop together → SP stays FFFF and regErr pulses once.
- wrWide to DD with wrData=34, wrDataHi=12; leftWide=1, leftSel=0 → leftData=1234 one cycle later.
- wrWide to index 0 (GPR) → no register changes, regErr=1 for exactly one cycle.
- Write A=5A and select rightSel=1 in the same cycle → rightData=5A next cycle with R88_REGFILE_FWD_EN, old A=00 without it; also wrEn on PC low together with incPC → the write wins.

Source files
------------

// File: rtl/r88_regfile_gen_pkg.sv
// r88_pkg: shared constants and index helpers for the Rocket88 register file.
//   - Default reset values for PC and SP.
//   - Status register bit positions {S,Z,C,I,D,B,0,0}.
//   - Index helpers for pair low bytes, the STATUS slot, and the PC/SP pair roles.
package r88_pkg;

    localparam logic [15:0] R88_RESET_PC = 16'h0000;
    localparam logic [15:0] R88_RESET_SP = 16'hFFF9;

    localparam int unsigned STAT_S = 7;
    localparam int unsigned STAT_Z = 6;
    localparam int unsigned STAT_C = 5;
    localparam int unsigned STAT_I = 4;
    localparam int unsigned STAT_D = 3;
    localparam int unsigned STAT_B = 2;

    // Flat index of the low byte of pair p.
    function automatic int unsigned pair_lo_idx(input int unsigned num_gpr,
                                                input int unsigned p);
        return num_gpr + 2 * p;
    endfunction

    // STATUS is the last register in the flat index map.
    function automatic int unsigned status_idx(input int unsigned num_gpr,
                                               input int unsigned num_pair);
        return num_gpr + 2 * num_pair;
    endfunction

    // The last two pairs are PC then SP.
    function automatic int unsigned pc_pair(input int unsigned num_pair);
        return num_pair - 2;
    endfunction

    function automatic int unsigned sp_pair(input int unsigned num_pair);
        return num_pair - 1;
    endfunction

endpackage

// File: rtl/r88_regfile_gen_ptr_reg.sv
// r88_ptr_reg: one 2*DATA_W pointer pair with byte/wide write and +1/-1 adjust.
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   wr_lo, wr_hi      byte write enables (both for a wide write)
//   lo_data, hi_data  write data for the low / high byte
//   inc, dec          +1 / -1 adjust (both together: hold)
//   value             current register contents
//   next_value        value that will be loaded on the next edge
// Any write to the pair outranks the adjust; the unwritten byte holds.
module r88_ptr_reg
    import r88_pkg::*;
#(
    parameter int unsigned          DATA_W    = 8,
    parameter logic [2*DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_lo,
    input  logic                  wr_hi,
    input  logic [DATA_W-1:0]     lo_data,
    input  logic [DATA_W-1:0]     hi_data,
    input  logic                  inc,
    input  logic                  dec,
    output logic [2*DATA_W-1:0]   value,
    output logic [2*DATA_W-1:0]   next_value
);

    localparam int unsigned ADDR_W = 2 * DATA_W;

    always_comb begin
        next_value = value;
        if (wr_lo || wr_hi) begin
            if (wr_lo) next_value[DATA_W-1:0]      = lo_data;
            if (wr_hi) next_value[ADDR_W-1:DATA_W] = hi_data;
        end else if (inc && !dec) begin
            next_value = value + ADDR_W'(1);
        end else if (dec && !inc) begin
            next_value = value - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value <= RESET_VAL;
        else        value <= next_value;
    end

endmodule

// File: rtl/r88_regfile_gen.sv
// r88_regfile_gen: parametrised Rocket88 register file.
//   GPRs, NUM_PAIR pointer pairs (last two are PC, SP), and a STATUS register,
//   with registered bus, ALU and address operand outputs.
// Ports:
//   sysClock, sysResetN            clock, asynchronous active-low reset
//   wrEn/wrSel/wrWide/wrData/wrDataHi   register write port
//   rdSel -> rdData                registered bus read
//   rightSel -> rightData          registered ALU right operand (0 = zero)
//   leftSel/leftWide -> leftData   registered ALU left operand
//   addrSel -> addrOut             registered address (0 = {GPR1,GPR2})
//   incPC, spPush, spPop           PC/SP adjust strobes
//   flagsLoad/flagsIn -> flagsOut  status load, live status
//   regErr                         one-cycle pulse on an illegal access
// Build option: R88_REGFILE_FWD_EN makes the registered read outputs show the
// post-update register values written/adjusted on the same edge.
module r88_regfile_gen
    import r88_pkg::*;
#(
    parameter int unsigned          DATA_W   = 8,
    parameter int unsigned          NUM_GPR  = 3,
    parameter int unsigned          NUM_PAIR = 4,
    parameter logic [2*DATA_W-1:0]  RESET_PC = R88_RESET_PC,
    parameter logic [2*DATA_W-1:0]  RESET_SP = R88_RESET_SP,
    localparam int unsigned ADDR_W = 2 * DATA_W,
    localparam int unsigned NREG   = NUM_GPR + 2 * NUM_PAIR + 1,
    localparam int unsigned SEL_W  = $clog2(NREG),
    localparam int unsigned RSEL_W = $clog2(NUM_GPR + 1),
    localparam int unsigned LSEL_W = $clog2(NUM_PAIR),
    localparam int unsigned ASEL_W = $clog2(NUM_PAIR + 1)
) (
    input  logic               sysClock,
    input  logic               sysResetN,
    input  logic               wrEn,
    input  logic [SEL_W-1:0]   wrSel,
    input  logic               wrWide,
    input  logic [DATA_W-1:0]  wrData,
    input  logic [DATA_W-1:0]  wrDataHi,
    input  logic [SEL_W-1:0]   rdSel,
    output logic [DATA_W-1:0]  rdData,
    input  logic [RSEL_W-1:0]  rightSel,
    output logic [DATA_W-1:0]  rightData,
    input  logic [LSEL_W-1:0]  leftSel,
    input  logic               leftWide,
    output logic [ADDR_W-1:0]  leftData,
    input  logic [ASEL_W-1:0]  addrSel,
    output logic [ADDR_W-1:0]  addrOut,
    input  logic               incPC,
    input  logic               spPush,
    input  logic               spPop,
    input  logic               flagsLoad,
    input  logic [DATA_W-1:0]  flagsIn,
    output logic [DATA_W-1:0]  flagsOut,
    output logic               regErr
);

    localparam int unsigned PC_PAIR  = pc_pair(NUM_PAIR);
    localparam int unsigned SP_PAIR  = sp_pair(NUM_PAIR);
    localparam int unsigned STAT_IDX = status_idx(NUM_GPR, NUM_PAIR);
    localparam int unsigned PAIR_END = NUM_GPR + 2 * NUM_PAIR;

`ifdef R88_REGFILE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic [DATA_W-1:0] gpr      [NUM_GPR];
    logic [DATA_W-1:0] gpr_nxt  [NUM_GPR];
    logic [DATA_W-1:0] status, status_nxt;
    logic [ADDR_W-1:0] pair_val [NUM_PAIR];
    logic [ADDR_W-1:0] pair_nxt [NUM_PAIR];

    logic [DATA_W-1:0] cur_b [NREG];
    logic [DATA_W-1:0] nxt_b [NREG];
    logic [DATA_W-1:0] src   [NREG];

    logic [31:0]       ws;
    logic              sel_ok, lo_pos, wide_bad, wr_ok, err_nxt;
    logic [DATA_W-1:0] hi_data;

    // ---------------- write decode ----------------
    assign ws      = 32'(wrSel);
    assign hi_data = wrWide ? wrDataHi : wrData;

    always_comb begin
        sel_ok   = (ws < NREG);
        lo_pos   = (ws >= NUM_GPR) && (ws < PAIR_END) && (((ws - NUM_GPR) % 2) == 0);
        wide_bad = wrWide && !lo_pos;
        wr_ok    = wrEn && sel_ok && !wide_bad;
        err_nxt  = (wrEn && (!sel_ok || wide_bad)) || (spPush && spPop);
    end

    // ---------------- GPRs and STATUS ----------------
    always_comb begin
        gpr_nxt = gpr;
        for (int unsigned g = 0; g < NUM_GPR; g++) begin
            if (wr_ok && !wrWide && ws == g) gpr_nxt[g] = wrData;
        end
        status_nxt = status;
        if (wr_ok && !wrWide && ws == STAT_IDX) status_nxt = wrData;
        else if (flagsLoad)                     status_nxt = flagsIn;
    end

    always_ff @(posedge sysClock or negedge sysResetN) begin
        if (!sysResetN) begin
            for (int unsigned g = 0; g < NUM_GPR; g++) gpr[g] <= '0;
            status <= '0;
        end else begin
            gpr    <= gpr_nxt;
            status <= status_nxt;
        end
    end

    assign flagsOut = status;

    // ---------------- pointer pairs ----------------
    for (genvar p = 0; p < NUM_PAIR; p++) begin : g_pair
        localparam int unsigned PLO = pair_lo_idx(NUM_GPR, p);
        localparam logic [ADDR_W-1:0] RVAL =
            (p == PC_PAIR) ? RESET_PC : (p == SP_PAIR) ? RESET_SP : '0;

        logic wr_lo, wr_hi, adj_inc, adj_dec;

        assign wr_lo = wr_ok && (ws == PLO);
        assign wr_hi = wr_ok && (wrWide ? (ws == PLO) : (ws == PLO + 1));

        if (p == PC_PAIR) begin : g_pc
            assign adj_inc = incPC;
            assign adj_dec = 1'b0;
        end else if (p == SP_PAIR) begin : g_sp
            assign adj_inc = spPop;
            assign adj_dec = spPush;
        end else begin : g_plain
            assign adj_inc = 1'b0;
            assign adj_dec = 1'b0;
        end

        r88_ptr_reg #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RVAL)
        ) u_ptr (
            .clk        (sysClock),
            .rst_n      (sysResetN),
            .wr_lo      (wr_lo),
            .wr_hi      (wr_hi),
            .lo_data    (wrData),
            .hi_data    (hi_data),
            .inc        (adj_inc),
            .dec        (adj_dec),
            .value      (pair_val[p]),
            .next_value (pair_nxt[p])
        );
    end

    // ---------------- flat byte view and read source ----------------
    always_comb begin
        for (int unsigned g = 0; g < NUM_GPR; g++) begin
            cur_b[g] = gpr[g];
            nxt_b[g] = gpr_nxt[g];
        end
        for (int unsigned p = 0; p < NUM_PAIR; p++) begin
            cur_b[NUM_GPR + 2*p]     = pair_val[p][DATA_W-1:0];
            cur_b[NUM_GPR + 2*p + 1] = pair_val[p][ADDR_W-1:DATA_W];
            nxt_b[NUM_GPR + 2*p]     = pair_nxt[p][DATA_W-1:0];
            nxt_b[NUM_GPR + 2*p + 1] = pair_nxt[p][ADDR_W-1:DATA_W];
        end
        cur_b[STAT_IDX] = status;
        nxt_b[STAT_IDX] = status_nxt;
        for (int unsigned i = 0; i < NREG; i++) src[i] = FWD ? nxt_b[i] : cur_b[i];
    end

    // ---------------- read muxes ----------------
    logic [DATA_W-1:0] rd_n, right_n;
    logic [ADDR_W-1:0] left_n, addr_n, gpr_ptr;

    if (NUM_GPR >= 3) begin : g_gptr
        assign gpr_ptr = {src[1], src[2]};
    end else begin : g_nogptr
        assign gpr_ptr = '0;
    end

    always_comb begin
        rd_n = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (32'(rdSel) == i) rd_n = src[i];
        end

        right_n = '0;
        for (int unsigned g = 0; g < NUM_GPR; g++) begin
            if (32'(rightSel) == g + 1) right_n = src[g];
        end

        left_n = '0;
        if (leftWide) begin
            for (int unsigned p = 0; p < NUM_PAIR; p++) begin
                if (32'(leftSel) == p)
                    left_n = {src[NUM_GPR + 2*p + 1], src[NUM_GPR + 2*p]};
            end
        end else begin
            for (int unsigned g = 0; g < NUM_GPR; g++) begin
                if (32'(leftSel) == g + 1) left_n = ADDR_W'(src[g]);
            end
        end

        addr_n = '0;
        if (addrSel == '0) addr_n = gpr_ptr;
        for (int unsigned p = 0; p < NUM_PAIR; p++) begin
            if (32'(addrSel) == p + 1)
                addr_n = {src[NUM_GPR + 2*p + 1], src[NUM_GPR + 2*p]};
        end
    end

    always_ff @(posedge sysClock or negedge sysResetN) begin
        if (!sysResetN) begin
            rdData    <= '0;
            rightData <= '0;
            leftData  <= '0;
            addrOut   <= '0;
            regErr    <= 1'b0;
        end else begin
            rdData    <= rd_n;
            rightData <= right_n;
            leftData  <= left_n;
            addrOut   <= addr_n;
            regErr    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_r88_regfile_gen.sv
// Bench for r88_regfile_gen with default parameters: a byte-array model of the
// register file checked every cycle, plus literal expectations at key points.
module tb_r88_regfile_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrEn, wrWide, leftWide, incPC, spPush, spPop, flagsLoad;
    logic [3:0]  wrSel, rdSel;
    logic [7:0]  wrData, wrDataHi, flagsIn;
    logic [1:0]  rightSel, leftSel;
    logic [2:0]  addrSel;
    logic [7:0]  rdData, rightData, flagsOut;
    logic [15:0] leftData, addrOut;
    logic        regErr;

    always #5 clk = ~clk;

    r88_regfile_gen dut (
        .sysClock (clk),      .sysResetN (rst_n),
        .wrEn     (wrEn),     .wrSel     (wrSel),    .wrWide   (wrWide),
        .wrData   (wrData),   .wrDataHi  (wrDataHi), .rdSel    (rdSel),
        .rdData   (rdData),   .rightSel  (rightSel), .rightData(rightData),
        .leftSel  (leftSel),  .leftWide  (leftWide), .leftData (leftData),
        .addrSel  (addrSel),  .addrOut   (addrOut),  .incPC    (incPC),
        .spPush   (spPush),   .spPop     (spPop),    .flagsLoad(flagsLoad),
        .flagsIn  (flagsIn),  .flagsOut  (flagsOut), .regErr   (regErr)
    );

    // Model: m[0..2] GPRs, pairs DD(3,4) EE(5,6) PC(7,8) SP(9,10), STATUS 11.
    bit   [7:0]  m [12];
    logic [7:0]  e_rd, e_right;
    logic [15:0] e_left, e_addr;
    logic        e_err;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic void model_reset();
        for (int i = 0; i < 12; i++) m[i] = 8'h00;
        m[9] = 8'hF9; m[10] = 8'hFF;
        e_rd = 0; e_right = 0; e_left = 0; e_addr = 0; e_err = 0;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n) begin
            bit [7:0]  o [12];
            bit [7:0]  n [12];
            bit [7:0]  s [12];
            bit        err, pc_w, sp_w, st_w;
            int        w, a, l, r;
            bit [15:0] v;
            o = m; n = m; err = 0; pc_w = 0; sp_w = 0; st_w = 0; w = int'(wrSel);
            if (wrEn) begin
                if (w >= 12) err = 1;
                else if (wrWide) begin
                    if (w >= 3 && w <= 9 && ((w - 3) % 2) == 0) begin
                        n[w] = wrData; n[w+1] = wrDataHi;
                    end else err = 1;
                end else n[w] = wrData;
                if (!err) begin
                    pc_w = (w == 7 || w == 8);
                    sp_w = (w == 9 || w == 10);
                    st_w = (w == 11);
                end
            end
            if (flagsLoad && !st_w) n[11] = flagsIn;
            if (incPC && !pc_w) begin
                v = {n[8], n[7]} + 16'd1; n[8] = v[15:8]; n[7] = v[7:0];
            end
            if (spPush && spPop) err = 1;
            else if (!sp_w && (spPush || spPop)) begin
                v = {n[10], n[9]};
                v = spPush ? v - 16'd1 : v + 16'd1;
                n[10] = v[15:8]; n[9] = v[7:0];
            end
`ifdef R88_REGFILE_FWD_EN
            s = n;
`else
            s = o;
`endif
            e_rd    = (int'(rdSel) < 12) ? s[rdSel] : 8'h00;
            r       = int'(rightSel);
            e_right = (r == 0) ? 8'h00 : s[r-1];
            l       = int'(leftSel);
            if (leftWide)    e_left = {s[3 + 2*l + 1], s[3 + 2*l]};
            else if (l == 0) e_left = 16'h0000;
            else             e_left = {8'h00, s[l-1]};
            a = int'(addrSel);
            if (a == 0)      e_addr = {s[1], s[2]};
            else if (a <= 4) e_addr = {s[3 + 2*(a-1) + 1], s[3 + 2*(a-1)]};
            else             e_addr = 16'h0000;
            e_err = err;
            m = n;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("rdData",    {8'h00, rdData},    {8'h00, e_rd});
        chk("rightData", {8'h00, rightData}, {8'h00, e_right});
        chk("leftData",  leftData,           e_left);
        chk("addrOut",   addrOut,            e_addr);
        chk("regErr",    {15'd0, regErr},    {15'd0, e_err});
        chk("flagsOut",  {8'h00, flagsOut},  {8'h00, m[11]});
    end

    task automatic idle();
        wrEn = 0; wrSel = 0; wrWide = 0; wrData = 0; wrDataHi = 0; rdSel = 0;
        rightSel = 0; leftSel = 0; leftWide = 0; addrSel = 0;
        incPC = 0; spPush = 0; spPop = 0; flagsLoad = 0; flagsIn = 0;
    endtask

    // One clock: inputs set before the call are sampled at the posedge; returns
    // just after the following negedge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("lit_rst_rd",   {8'h00, rdData}, 16'h0000);
        chk("lit_rst_addr", addrOut, 16'h0000);
        chk("lit_rst_err",  {15'd0, regErr}, 16'h0000);
        rst_n = 1;

        addrSel = 3; cyc(); chk("lit_pc_reset", addrOut, 16'h0000);
        addrSel = 4; cyc(); chk("lit_sp_reset", addrOut, 16'hFFF9);
        idle(); rightSel = 1; cyc(); chk("lit_a_reset", {8'h00, rightData}, 16'h0000);

        // PC FFFF + 1 wraps to 0000
        idle(); wrEn = 1; wrSel = 7; wrData = 8'hFF; cyc();
        wrSel = 8; cyc();
        idle(); incPC = 1; cyc();
        idle(); addrSel = 3; cyc(); chk("lit_pc_wrap", addrOut, 16'h0000);

        // SP 0000 - 1 wraps to FFFF; push+pop together holds and flags error
        idle(); wrEn = 1; wrWide = 1; wrSel = 9; cyc();
        idle(); spPush = 1; cyc();
        spPop = 1; cyc(); chk("lit_pushpop_err", {15'd0, regErr}, 16'h0001);
        idle(); addrSel = 4; cyc();
        chk("lit_err_once", {15'd0, regErr}, 16'h0000);
        chk("lit_sp_wrap", addrOut, 16'hFFFF);

        // Wide write to DD, read back as 16-bit left operand
        idle(); wrEn = 1; wrWide = 1; wrSel = 3; wrData = 8'h34; wrDataHi = 8'h12; cyc();
        idle(); leftWide = 1; leftSel = 0; cyc(); chk("lit_dd_wide", leftData, 16'h1234);

        // Wide write at a GPR index: rejected
        idle(); wrEn = 1; wrWide = 1; wrSel = 0; wrData = 8'h77; wrDataHi = 8'h66; cyc();
        chk("lit_wide_err", {15'd0, regErr}, 16'h0001);
        idle(); rightSel = 1; cyc();
        chk("lit_wide_err_clr", {15'd0, regErr}, 16'h0000);
        chk("lit_wide_nowrite", {8'h00, rightData}, 16'h0000);

        // Write A and read it on the same edge
        idle(); wrEn = 1; wrSel = 0; wrData = 8'h5A; rightSel = 1; cyc();
`ifdef R88_REGFILE_FWD_EN
        chk("lit_same_cycle_a", {8'h00, rightData}, 16'h005A);
`else
        chk("lit_same_cycle_a", {8'h00, rightData}, 16'h0000);
`endif
        idle(); rightSel = 1; cyc(); chk("lit_a_after", {8'h00, rightData}, 16'h005A);

        // Write to PC low byte beats incPC
        idle(); wrEn = 1; wrSel = 7; wrData = 8'h12; incPC = 1; cyc();
        idle(); addrSel = 3; cyc(); chk("lit_write_wins", addrOut, 16'h0012);

        // Status load, write beating load, out-of-range write
        idle(); flagsLoad = 1; flagsIn = 8'hA4; cyc(); chk("lit_flags", {8'h00, flagsOut}, 16'h00A4);
        idle(); wrEn = 1; wrSel = 11; wrData = 8'h3C; flagsLoad = 1; flagsIn = 8'hFF; cyc();
        chk("lit_flags_wr", {8'h00, flagsOut}, 16'h003C);
        idle(); wrEn = 1; wrSel = 13; wrData = 8'h99; cyc();
        chk("lit_oob_err", {15'd0, regErr}, 16'h0001);

        // Held incPC adds one per cycle
        idle(); incPC = 1; repeat (3) cyc();
        idle(); addrSel = 3; cyc(); chk("lit_pc_hold", addrOut, 16'h0015);

        // Write-while-read table and read sweep
        for (int i = 0; i < 12; i++) begin
            idle();
            wrEn = 1; wrSel = 4'(i); wrData = 8'(8'h10 + i);
            rdSel = 4'(i); rightSel = 2'(i % 4); leftSel = 2'(i % 4);
            leftWide = i[1]; addrSel = 3'(i % 5);
            cyc();
        end
        for (int i = 0; i < 16; i++) begin
            idle();
            rdSel = 4'(i); rightSel = 2'(i % 4); leftSel = 2'((i / 2) % 4);
            leftWide = i[0]; addrSel = 3'(i % 8);
            if (i == 5) spPop = 1;
            cyc();
        end

        // Reset during a write takes effect without a clock edge
        idle(); wrEn = 1; wrSel = 0; wrData = 8'hEE; incPC = 1; flagsLoad = 1; flagsIn = 8'h55;
        @(posedge clk); #2;
        rst_n = 0; #1;
        chk("lit_arst_rd",    {8'h00, rdData},    16'h0000);
        chk("lit_arst_right", {8'h00, rightData}, 16'h0000);
        chk("lit_arst_left",  leftData,           16'h0000);
        chk("lit_arst_addr",  addrOut,            16'h0000);
        chk("lit_arst_flags", {8'h00, flagsOut},  16'h0000);
        @(negedge clk); #1;
        idle(); rst_n = 1;
        addrSel = 3; cyc(); chk("lit_arst_pc", addrOut, 16'h0000);
        addrSel = 4; cyc(); chk("lit_arst_sp", addrOut, 16'hFFF9);
        idle(); rightSel = 1; cyc(); chk("lit_arst_a", {8'h00, rightData}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
